// File: rtl/axi_sram_slave.sv
// AXI3 INCR-burst slave bridging serialized write/read bursts onto a single-port synchronous SRAM.
// Build option AXI_SLV_ERRCHK_EN: out-of-range address and WLAST consistency checking with SLVERR.
module axi_sram_slave #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              CEB,
  output logic [3:0]        WEB,
  output logic [MEM_AW-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

`ifdef AXI_SLV_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  localparam logic       PRIO_WR = 1'b0;
  localparam logic       PRIO_RD = 1'b1;
  localparam logic [1:0] RESP_OK = 2'b00;
  localparam logic [1:0] RESP_SE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    WRESP = 2'd2,
    RD    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              werr_q, werr_d;
  logic              woor_q, woor_d;
  logic              rerr_q, rerr_d;

  logic [MEM_AW-1:0] aw_word, ar_word, addr_inc;
  logic              aw_oor, ar_oor, last_beat;
  logic              unused_bits;

  assign aw_word   = AWADDR[MEM_AW+1:2];
  assign ar_word   = ARADDR[MEM_AW+1:2];
  assign addr_inc  = addr_q + MEM_AW'(1);
  assign last_beat = (cnt_q == 4'd0);

  // Address bits above the SRAM window only matter when range checking is built in.
  assign aw_oor = ERRCHK && (|AWADDR[ADDR_W-1:MEM_AW+2]);
  assign ar_oor = ERRCHK && (|ARADDR[ADDR_W-1:MEM_AW+2]);
  assign unused_bits = ^{AWADDR[1:0], ARADDR[1:0], AWADDR[ADDR_W-1:MEM_AW+2],
                         ARADDR[ADDR_W-1:MEM_AW+2], WLAST};

  assign DI     = WDATA;
  assign BID    = bid_q;
  assign RID    = rid_q;
  assign BVALID = (state_q == WRESP);
  assign BRESP  = werr_q ? RESP_SE : RESP_OK;
  assign RVALID = (state_q == RD);
  assign RLAST  = (state_q == RD) && last_beat;
  assign RRESP  = rerr_q ? RESP_SE : RESP_OK;
  assign RDATA  = rerr_q ? 32'h0 : DO;

  // State and burst context registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      prio_q  <= PRIO_WR;
      addr_q  <= '0;
      cnt_q   <= 4'd0;
      bid_q   <= '0;
      rid_q   <= '0;
      werr_q  <= 1'b0;
      woor_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      bid_q   <= bid_d;
      rid_q   <= rid_d;
      werr_q  <= werr_d;
      woor_q  <= woor_d;
      rerr_q  <= rerr_d;
    end
  end

  // Next state, channel handshakes and SRAM port drive.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bid_d   = bid_q;
    rid_d   = rid_q;
    werr_d  = werr_q;
    woor_d  = woor_q;
    rerr_d  = rerr_q;
    AWREADY = 1'b0;
    ARREADY = 1'b0;
    WREADY  = 1'b0;
    CEB     = 1'b1;
    WEB     = 4'hF;
    A       = addr_q;

    case (state_q)
      IDLE: begin
        // Round-robin: the channel without priority only wins when the other is idle.
        AWREADY = ARESETn && ((prio_q == PRIO_WR) || !ARVALID);
        ARREADY = ARESETn && ((prio_q == PRIO_RD) || !AWVALID);
        if (AWVALID && AWREADY) begin
          addr_d  = aw_word;
          cnt_d   = AWLEN;
          bid_d   = AWID;
          werr_d  = aw_oor;
          woor_d  = aw_oor;
          state_d = WR;
        end else if (ARVALID && ARREADY) begin
          CEB     = 1'b0;
          A       = ar_word;
          addr_d  = ar_word;
          cnt_d   = ARLEN;
          rid_d   = ARID;
          rerr_d  = ar_oor;
          state_d = RD;
        end
      end

      WR: begin
        WREADY = 1'b1;
        if (WVALID) begin
          CEB    = woor_q;
          WEB    = ~WSTRB;
          addr_d = addr_inc;
          cnt_d  = cnt_q - 4'd1;
          if (ERRCHK && (WLAST != last_beat)) begin
            werr_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WRESP;
          end
        end
      end

      WRESP: begin
        if (BREADY) begin
          state_d = IDLE;
          prio_d  = ~prio_q;
        end
      end

      RD: begin
        // Read-ahead only on a handshake so DO stays frozen while the master stalls.
        if (RREADY) begin
          if (last_beat) begin
            state_d = IDLE;
            prio_d  = ~prio_q;
          end else begin
            CEB    = 1'b0;
            A      = addr_inc;
            addr_d = addr_inc;
            cnt_d  = cnt_q - 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: SRAM macro model, expected W/B/R queues, negedge monitor.
module tb_axi_sram_slave;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MEM_AW = 14;

  logic              clk;
  logic              rst_n;
  logic [ID_W-1:0]   AWID, BID, ARID, RID;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [3:0]        AWLEN, ARLEN, WSTRB, WEB;
  logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB;
  logic [1:0]        BRESP, RRESP;
  logic [31:0]       WDATA, RDATA, DI, DO;
  logic [MEM_AW-1:0] A;

  typedef struct { logic [31:0] data; logic last; logic [7:0] id; logic [1:0] resp; } r_exp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [13:0] a; logic [3:0] web; logic [31:0] di; } w_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  w_exp_t      wq[$];
  logic [31:0] shadow [0:16383];
  logic [31:0] mem    [0:16383];
  logic        arrdy_at_aw;
  int          vectors;
  int          miscompares;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-port SRAM macro: 1-cycle read latency, output held while deselected.
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 ^ 32'(i);
    mem[14'h080] = 32'h1234_5678;
    DO <= 32'h0;
    forever begin
      @(posedge clk);
      if (!CEB) begin
        if (WEB == 4'hF) DO <= mem[A];
        else for (int b = 0; b < 4; b++) if (!WEB[b]) mem[A][8*b +: 8] = DI[8*b +: 8];
      end
    end
  end

  // Monitor: compares every SRAM write, B response and R beat with the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (AWVALID && AWREADY) arrdy_at_aw = ARREADY;
      if (!CEB && WEB != 4'hF) begin
        if (wq.size() == 0) check("sram_write_unexpected", 64'(1'b1), 64'(1'b0));
        else begin
          w_exp_t we;
          we = wq.pop_front();
          check("sram_a", 64'(A), 64'(we.a));
          check("sram_web", 64'(WEB), 64'(we.web));
          check("sram_di", 64'(DI), 64'(we.di));
        end
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) check("b_unexpected", 64'(1'b1), 64'(1'b0));
        else begin
          b_exp_t be;
          be = bq.pop_front();
          check("bid", 64'(BID), 64'(be.id));
          check("bresp", 64'(BRESP), 64'(be.resp));
        end
      end
      if (RVALID) begin
        if (rq.size() == 0) check("r_unexpected", 64'(1'b1), 64'(1'b0));
        else begin
          r_exp_t re;
          re = rq[0];
          check("rdata", 64'(RDATA), 64'(re.data));
          if (RREADY) begin
            void'(rq.pop_front());
            check("rlast", 64'(RLAST), 64'(re.last));
            check("rid", 64'(RID), 64'(re.id));
            check("rresp", 64'(RRESP), 64'(re.resp));
          end
        end
      end
    end
  end

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [31:0] d0, input logic [3:0] strb, input logic oor,
                             input logic bad_last);
    logic [13:0] w;
    logic [31:0] dd;
    w = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      dd = d0 + 32'(i);
      if (!oor) begin
        wq.push_back('{a: w, web: ~strb, di: dd});
        for (int b = 0; b < 4; b++) if (strb[b]) shadow[w][8*b +: 8] = dd[8*b +: 8];
      end
      w = w + 14'd1;
    end
    bq.push_back('{id: id, resp: ((oor || bad_last) ? 2'b10 : 2'b00)});
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    for (int k = 0; k < 64; k++) begin @(negedge clk); if (AWREADY) break; end
    check("aw_accept", 64'(AWREADY), 64'(1'b1));
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = d0 + 32'(i); WSTRB = strb; WVALID = 1'b1;
      WLAST = bad_last ? (i == 0) : (i == int'(len));
      for (int k = 0; k < 64; k++) begin @(negedge clk); if (WREADY) break; end
      check("w_accept", 64'(WREADY), 64'(1'b1));
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge clk);
    check("last_w_to_bvalid", 64'(BVALID), 64'(1'b1));
    @(posedge clk); #1;
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [6:0] pat, input logic oor, output int cycles);
    logic [13:0] w;
    int ph;
    w = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{data: (oor ? 32'h0 : shadow[w]), last: (i == int'(len)), id: id,
                     resp: (oor ? 2'b10 : 2'b00)});
      w = w + 14'd1;
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    for (int k = 0; k < 64; k++) begin @(negedge clk); if (ARREADY) break; end
    check("ar_accept", 64'(ARREADY), 64'(1'b1));
    @(posedge clk); #1;
    ARVALID = 1'b0; RREADY = pat[0];
    @(negedge clk);
    check("ar_to_rvalid", 64'(RVALID), 64'(1'b1));
    ph = 1; cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (rq.size() == 0) break;
      RREADY = pat[ph % 7];
      ph++;
    end
    check("r_drained", 64'(rq.size()), 64'(0));
    RREADY = 1'b1;
    @(negedge clk);
    check("r_idle", 64'(RVALID), 64'(1'b0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [13:0] w;
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 16384; i++) shadow[i] = 32'h5A00_0000 ^ 32'(i);
    shadow[14'h080] = 32'h1234_5678;
    rst_n = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(AWREADY), 64'(1'b0));
    check("rst_arready", 64'(ARREADY), 64'(1'b0));
    check("rst_wready", 64'(WREADY), 64'(1'b0));
    check("rst_bvalid", 64'(BVALID), 64'(1'b0));
    check("rst_rvalid", 64'(RVALID), 64'(1'b0));
    check("rst_rlast", 64'(RLAST), 64'(1'b0));
    check("rst_resp", 64'({BRESP, RRESP}), 64'(4'h0));
    check("rst_ids", 64'({BID, RID}), 64'(16'h0));
    check("rst_ceb", 64'(CEB), 64'(1'b1));
    check("rst_web", 64'(WEB), 64'(4'hF));
    check("rst_a", 64'(A), 64'(14'h0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous AW/AR after reset: write first, then the read sees the strobed merge.
    ARID = 8'h33; ARADDR = 32'h200; ARLEN = 4'd0; ARVALID = 1'b1;
    write_burst(8'h44, 32'h200, 4'd0, 32'hFFFF_FFFF, 4'b0011, 1'b0, 1'b0);
    check("arb_write_first", 64'(arrdy_at_aw), 64'(1'b0));
    read_burst(8'h33, 32'h200, 4'd0, 7'h7F, 1'b0, n);
    check("partial_strobe_expect", 64'(shadow[14'h080]), 64'(32'h1234_FFFF));

    write_burst(8'h15, 32'h100, 4'd3, 32'hA0, 4'hF, 1'b0, 1'b0);
    read_burst(8'h22, 32'h100, 4'd3, 7'h7F, 1'b0, n);
    check("r_burst_cycles", 64'(n), 64'(4));
    read_burst(8'h22, 32'h100, 4'd3, 7'b1011001, 1'b0, n);
    check("r_stall_cycles", 64'(n), 64'(7));

    // Word address wraps at the top of the SRAM.
    write_burst(8'h71, 32'h0000_FFFC, 4'd1, 32'hC0DE_0000, 4'hF, 1'b0, 1'b0);
    read_burst(8'h72, 32'h0000_FFFC, 4'd1, 7'h7F, 1'b0, n);

`ifdef AXI_SLV_ERRCHK_EN
    read_burst(8'h81, 32'h1000_0000, 4'd3, 7'h7F, 1'b1, n);
    write_burst(8'h82, 32'h1000_0000, 4'd1, 32'hBAD0, 4'hF, 1'b1, 1'b0);
    write_burst(8'h83, 32'h300, 4'd1, 32'hB0, 4'hF, 1'b0, 1'b1);
    read_burst(8'h84, 32'h300, 4'd1, 7'h7F, 1'b0, n);
`else
    read_burst(8'h81, 32'h1000_0100, 4'd3, 7'h7F, 1'b0, n);
`endif

    // Reset while beat 2 of 4 is on the bus, then a clean read.
    w = 14'h040;
    for (int i = 0; i < 4; i++) begin
      rq.push_back('{data: shadow[w], last: (i == 3), id: 8'h66, resp: 2'b00});
      w = w + 14'd1;
    end
    ARID = 8'h66; ARADDR = 32'h100; ARLEN = 4'd3; ARVALID = 1'b1;
    for (int k = 0; k < 64; k++) begin @(negedge clk); if (ARREADY) break; end
    check("ar_accept", 64'(ARREADY), 64'(1'b1));
    @(posedge clk); #1;
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(RVALID), 64'(1'b0));
    check("rst_mid_rlast", 64'(RLAST), 64'(1'b0));
    check("rst_mid_ceb", 64'(CEB), 64'(1'b1));
    rq.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    read_burst(8'h67, 32'h100, 4'd3, 7'h7F, 1'b0, n);
    check("post_rst_cycles", 64'(n), 64'(4));

    repeat (3) @(posedge clk);
    check("queues_empty", 64'(rq.size() + bq.size() + wq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
